// File: rtl/pll_reset_sequencer_if.sv
// Status and control bundle between the PLL reset sequencer and the PLL/system reset fabric.
// The sequencer takes the master side; the PLL/reset consumers take the slave side.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  modport master (
    input  locked,
    output pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: pulses pll_rst, waits for synchronised lock, releases sys_rst after a stable window.
// Outputs registered on the state-transition edge; locked rise -> ready in STABLE_CYCLES+3 edges; no backpressure.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RP_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    retry_q, retry_nxt;
  logic [7:0]    loss_q, loss_nxt;
  logic          sync_q, locked_s;
  logic          pll_rst_q, sys_rst_q, ready_q, fail_q;

  // locked comes straight from the PLL analog block, asynchronous to refclk
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= bus.locked;
      locked_s <= sync_q;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_q   <= retry_nxt;
      loss_q    <= loss_nxt;
      pll_rst_q <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      sys_rst_q <= (state_nxt != S_RUN);
      ready_q   <= (state_nxt == S_RUN);
      fail_q    <= (state_nxt == S_FAULT);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_q;
    loss_nxt  = loss_q;
    case (state)
      S_RESET_PLL: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == RP_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_nxt = cnt + CW'(1);
        if (locked_s) begin
          state_nxt = S_STABILIZE;
        end else if (cnt == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_nxt = S_FAULT;
          end else begin
            retry_nxt = retry_q + 4'd1;
            state_nxt = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        cnt_nxt = cnt + CW'(1);
        // a single low sample restarts the wait without consuming a retry
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == ST_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_RESET_PLL;
          if (loss_q != 8'hFF) loss_nxt = loss_q + 8'd1;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_RESET_PLL;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fail            = fail_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: lock waveforms per edge are checked against an attempt-level sequence model.
module tb_pll_reset_sequencer;
  localparam int RP   = 4;
  localparam int TO   = 20;
  localparam int ST   = 8;
  localparam int MAXR = 2;
  localparam int MAXN = 400;
  localparam logic [15:0] RST_VAL = 16'hC000;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES      (ST),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  // lk[e] is driven just after edge e; obs/exp_v[e] are outputs after edge e (edge 0 = last edge in reset)
  logic        lk    [MAXN];
  logic [15:0] obs   [MAXN];
  logic [15:0] exp_v [MAXN];
  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] pack();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.retry_count, bus.lock_loss_count};
  endfunction

  task automatic set_lk(input int lo, input int hi, input logic v);
    for (int i = lo; i <= hi && i < MAXN; i++) if (i >= 0) lk[i] = v;
  endtask

  task automatic run(input int n);
    rst = 1'b1;
    bus.locked = 1'b0;
    @(posedge refclk); #1;
    @(posedge refclk); #1;
    obs[0] = pack();
    rst = 1'b0;
    bus.locked = lk[0];
    for (int e = 1; e <= n; e++) begin
      @(posedge refclk); #1;
      obs[e] = pack();
      bus.locked = lk[e];
    end
  endtask

  // value of the synchronised lock that the decision at edge m is based on
  function automatic logic ls(input int m);
    if (m < 3) return 1'b0;
    if (m - 3 >= MAXN) return lk[MAXN-1];
    return lk[m-3];
  endfunction

  task automatic fill(input int lo, input int hi, input logic [3:0] flags, input int rc, input int lc);
    for (int i = lo; i <= hi && i < MAXN; i++) if (i >= 0) exp_v[i] = {flags, 4'(rc), 8'(lc)};
  endtask

  // flags = {pll_rst, sys_rst, ready, fail}
  task automatic model(input int n);
    int t, rc, lc, m, k;
    bit done, running, retry;
    t = 0; rc = 0; lc = 0; done = 0;
    while (!done && t <= n) begin
      fill(t, t + RP - 1, 4'hC, rc, lc);
      t += RP;
      running = 0; retry = 0;
      while (!running && !retry && !done && t <= n) begin
        m = 0;
        for (int j = 1; j <= TO; j++) if (m == 0 && ls(t + j)) m = t + j;
        if (m == 0) begin
          fill(t, t + TO - 1, 4'h4, rc, lc);
          t += TO;
          if (rc == MAXR) begin
            fill(t, MAXN - 1, 4'hD, rc, lc);
            done = 1;
          end else begin
            rc++;
            retry = 1;
          end
        end else begin
          fill(t, m - 1, 4'h4, rc, lc);
          t = m;
          k = 0;
          for (int j = 1; j <= ST; j++) if (k == 0 && !ls(t + j)) k = t + j;
          if (k != 0) begin
            fill(t, k - 1, 4'h4, rc, lc);
            t = k;
          end else begin
            fill(t, t + ST - 1, 4'h4, rc, lc);
            t += ST;
            rc = 0;
            running = 1;
          end
        end
      end
      if (running) begin
        m = 0;
        for (int j = t + 1; j < t + MAXN && m == 0; j++) if (!ls(j)) m = j;
        if (m == 0) begin
          fill(t, MAXN - 1, 4'h2, rc, lc);
          done = 1;
        end else begin
          fill(t, m - 1, 4'h2, rc, lc);
          t = m;
          if (lc < 255) lc++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.locked = i[0];
      @(posedge refclk); #1;
      checks++;
      if (pack() !== RST_VAL) begin
        failures++;
        $display("FAIL reset_state cycle=%0d got=%h exp=%h", i, pack(), RST_VAL);
      end
    end
  endtask

  task automatic test_normal_lock();
    int d, n;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 10 : int'($urandom_range(0, 17));
      set_lk(0, MAXN - 1, 1'b0);
      set_lk(4 + d, MAXN - 1, 1'b1);
      n = 4 + d + 11 + 4;
      run(n);
      model(n);
      for (int e = 0; e <= n; e++) begin
        checks++;
        if (obs[e] !== exp_v[e]) begin
          failures++;
          $display("FAIL normal_lock d=%0d edge=%0d got=%h exp=%h", d, e, obs[e], exp_v[e]);
        end
      end
      checks++;
      if (obs[4+d+10][13] !== 1'b0 || obs[4+d+11][13] !== 1'b1 || obs[4+d+11][14] !== 1'b0 ||
          obs[4+d+11][11:8] !== 4'd0) begin
        failures++;
        $display("FAIL lock_latency d=%0d got_before=%h got_at=%h exp ready rising 11 edges after lock",
                 d, obs[4+d+10], obs[4+d+11]);
      end
    end
  endtask

  task automatic test_never_lock();
    int npll;
    set_lk(0, MAXN - 1, 1'b0);
    run(80);
    model(80);
    for (int e = 0; e <= 80; e++) begin
      checks++;
      if (obs[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL never_lock edge=%0d got=%h exp=%h", e, obs[e], exp_v[e]);
      end
    end
    npll = 0;
    for (int e = 0; e < 72; e++) if (obs[e][15]) npll++;
    checks++;
    if (npll != 12) begin
      failures++;
      $display("FAIL pll_pulse_cycles got=%0d exp=12", npll);
    end
    checks++;
    if (obs[71][12] !== 1'b0 || obs[72][12] !== 1'b1 || obs[80][11:8] !== 4'd2 || obs[80][15] !== 1'b1) begin
      failures++;
      $display("FAIL fault_timing got71=%h got72=%h got80=%h exp fail at edge 72 retry 2", obs[71], obs[72], obs[80]);
    end
  endtask

  task automatic test_glitch();
    int r, h, n;
    for (int it = 0; it < 4; it++) begin
      r = (it == 0) ? 10 : int'($urandom_range(0, 10));
      h = (it == 0) ? 5 : int'($urandom_range(1, 7));
      set_lk(0, MAXN - 1, 1'b0);
      set_lk(4 + r, 4 + r + h - 1, 1'b1);
      set_lk(4 + r + h + 1, MAXN - 1, 1'b1);
      n = 4 + r + h + 1 + 11 + 3;
      run(n);
      model(n);
      for (int e = 0; e <= n; e++) begin
        checks++;
        if (obs[e] !== exp_v[e]) begin
          failures++;
          $display("FAIL glitch r=%0d h=%0d edge=%0d got=%h exp=%h", r, h, e, obs[e], exp_v[e]);
        end
      end
      checks++;
      if (obs[4+r+h+11][13] !== 1'b0 || obs[4+r+h+12][13] !== 1'b1 || obs[4+r+h+12][11:8] !== 4'd0) begin
        failures++;
        $display("FAIL glitch_latency r=%0d h=%0d got_before=%h got_at=%h", r, h, obs[4+r+h+11], obs[4+r+h+12]);
      end
    end
  endtask

  task automatic test_loss_in_run();
    set_lk(0, MAXN - 1, 1'b0);
    set_lk(14, MAXN - 1, 1'b1);
    set_lk(30, 32, 1'b0);
    run(55);
    model(55);
    for (int e = 0; e <= 55; e++) begin
      checks++;
      if (obs[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL loss_in_run edge=%0d got=%h exp=%h", e, obs[e], exp_v[e]);
      end
    end
    checks++;
    if (obs[32][14] !== 1'b0 || obs[33][14] !== 1'b1 || obs[36][15] !== 1'b1 || obs[37][15] !== 1'b0 ||
        obs[55][13] !== 1'b1 || obs[55][7:0] !== 8'd1) begin
      failures++;
      $display("FAIL loss_timing got32=%h got33=%h got37=%h got55=%h", obs[32], obs[33], obs[37], obs[55]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pack() !== RST_VAL) begin
      failures++;
      $display("FAIL async_reset_run got=%h exp=%h", pack(), RST_VAL);
    end
  endtask

  task automatic test_retry_then_lock();
    set_lk(0, MAXN - 1, 1'b0);
    set_lk(30, MAXN - 1, 1'b1);
    run(45);
    model(45);
    for (int e = 0; e <= 45; e++) begin
      checks++;
      if (obs[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL retry_then_lock edge=%0d got=%h exp=%h", e, obs[e], exp_v[e]);
      end
    end
    checks++;
    if (obs[40][11:8] !== 4'd1 || obs[41][11:8] !== 4'd0 || obs[41][13] !== 1'b1) begin
      failures++;
      $display("FAIL retry_clear got40=%h got41=%h exp retry 1 then 0 on ready", obs[40], obs[41]);
    end
  endtask

  task automatic test_locked_at_reset();
    set_lk(0, MAXN - 1, 1'b1);
    run(20);
    model(20);
    for (int e = 0; e <= 20; e++) begin
      checks++;
      if (obs[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL locked_at_reset edge=%0d got=%h exp=%h", e, obs[e], exp_v[e]);
      end
    end
    checks++;
    if (obs[3][15] !== 1'b1 || obs[4][15] !== 1'b0 || obs[12][13] !== 1'b0 || obs[13][13] !== 1'b1) begin
      failures++;
      $display("FAIL full_pulse got3=%h got4=%h got13=%h", obs[3], obs[4], obs[13]);
    end
  endtask

  task automatic test_async_reset();
    set_lk(0, MAXN - 1, 1'b0);
    set_lk(14, MAXN - 1, 1'b1);
    run(20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pack() !== RST_VAL) begin
      failures++;
      $display("FAIL async_reset_stabilize got=%h exp=%h", pack(), RST_VAL);
    end
    set_lk(0, MAXN - 1, 1'b0);
    run(76);
    checks++;
    if (obs[76][12] !== 1'b1 || obs[76][13] !== 1'b0) begin
      failures++;
      $display("FAIL fault_held got=%h exp fail=1 ready=0", obs[76]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pack() !== RST_VAL) begin
      failures++;
      $display("FAIL async_reset_fault got=%h exp=%h", pack(), RST_VAL);
    end
  endtask

  task automatic test_random();
    int i, len, n;
    logic v;
    for (int it = 0; it < 6; it++) begin
      i = 0;
      v = 1'b0;
      while (i < MAXN) begin
        case ($urandom_range(0, 3))
          0:       len = int'($urandom_range(1, 4));
          1:       len = int'($urandom_range(5, 15));
          2:       len = int'($urandom_range(16, 50));
          default: len = int'($urandom_range(50, 90));
        endcase
        set_lk(i, i + len - 1, v);
        i += len;
        v = ~v;
      end
      n = 300;
      run(n);
      model(n);
      for (int e = 0; e <= n; e++) begin
        checks++;
        if (obs[e] !== exp_v[e] || (obs[e][13] && obs[e][12])) begin
          failures++;
          $display("FAIL random it=%0d edge=%0d got=%h exp=%h", it, e, obs[e], exp_v[e]);
        end
      end
    end
  endtask

  initial begin
    bus.locked = 1'b0;
    test_reset();
    test_normal_lock();
    test_never_lock();
    test_glitch();
    test_loss_in_run();
    test_retry_then_lock();
    test_locked_at_reset();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
